// File: rtl/mem_io_responder_if.sv
// CPU byte bus between the core and the memory/I/O responder.
// The CPU drives the address, write data and write flag; the responder returns read data and TX back-pressure.
interface mem_io_responder_if;
    logic [31:0] cpu_a;
    logic [7:0]  cpu_dout;
    logic        cpu_wr;
    logic [7:0]  cpu_din;
    logic        io_buffer_full;

    modport master (
        output cpu_a,
        output cpu_dout,
        output cpu_wr,
        input  cpu_din,
        input  io_buffer_full
    );

    modport slave (
        input  cpu_a,
        input  cpu_dout,
        input  cpu_wr,
        output cpu_din,
        output io_buffer_full
    );
endinterface

// File: rtl/mem_io_responder.sv
// Byte RAM with one-cycle reads, plus an I/O window at 0x30000 (UART) and 0x30004..7 (cycle counter / stop).
// CPU output bytes are queued in a TX FIFO whose near-full state is fed back on the bus.
module mem_io_responder #(
    parameter int ADDR_WIDTH   = 17,
    parameter int TX_DEPTH_LOG = 4
) (
    input  logic                clk_in,
    input  logic                rst_in,
    mem_io_responder_if.slave   bus,
    input  logic                rx_valid,
    input  logic [7:0]          rx_data,
    output logic                rx_pop,
    output logic                tx_valid,
    output logic [7:0]          tx_data,
    input  logic                tx_ready,
    output logic                program_done
);
    localparam int TX_DEPTH = 1 << TX_DEPTH_LOG;
    localparam int CW       = TX_DEPTH_LOG + 1;

    logic [7:0]              r_ram [0:(1<<ADDR_WIDTH)-1];
    logic [7:0]              r_ram_rd;
    logic                    r_sel_ram;
    logic [7:0]              r_io_data;
    logic [31:0]             r_cycle_cnt;
    logic [31:0]             r_cnt_latch;
    logic                    r_done;
    logic [7:0]              r_fifo [0:TX_DEPTH-1];
    logic [TX_DEPTH_LOG-1:0] r_head;
    logic [TX_DEPTH_LOG-1:0] r_tail;
    logic [CW-1:0]           r_count;
    logic                    r_io_full;

    logic                    w_is_io;
    logic [2:0]              w_off;
    logic                    w_io_rd;
    logic                    w_io_wr;
    logic [ADDR_WIDTH-1:0]   w_ram_addr;
    logic                    w_ram_we;
    logic                    w_ram_re;
    logic [7:0]              w_io_rd_data;
    logic [7:0]              w_latch_byte [0:3];
    logic                    w_fifo_full;
    logic                    w_push;
    logic [7:0]              w_push_data;
    logic                    w_pop;
    logic [CW-1:0]           w_count_next;
    logic                    w_unused_addr;

    assign w_is_io    = (bus.cpu_a[17:16] == 2'b11);
    assign w_off      = bus.cpu_a[2:0];
    assign w_io_rd    = w_is_io && !bus.cpu_wr;
    assign w_io_wr    = w_is_io && bus.cpu_wr;
    assign w_ram_addr = bus.cpu_a[ADDR_WIDTH-1:0];
    assign w_ram_we   = !w_is_io && bus.cpu_wr;
    assign w_ram_re   = !w_is_io && !bus.cpu_wr;
    assign w_unused_addr = ^bus.cpu_a[31:18];

    assign rx_pop = w_io_rd && (w_off == 3'd0) && rx_valid;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_latch_lane
            assign w_latch_byte[gi] = r_cnt_latch[8*gi +: 8];
        end
    endgenerate

    // Offset 4 returns the live low byte; 5..7 come from the snapshot taken by that same read.
    always_comb begin
        w_io_rd_data = 8'h00;
        if (w_off == 3'd0)
            w_io_rd_data = rx_valid ? rx_data : 8'h00;
        else if (w_off == 3'd4)
            w_io_rd_data = r_cycle_cnt[7:0];
        else if (w_off[2])
            w_io_rd_data = w_latch_byte[w_off[1:0]];
    end

    always_ff @(posedge clk_in) begin
        if (w_ram_we)
            r_ram[w_ram_addr] <= bus.cpu_dout;
        if (w_ram_re)
            r_ram_rd <= r_ram[w_ram_addr];
    end

    // Response source is registered alongside the data so write cycles leave cpu_din untouched.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_sel_ram <= 1'b0;
            r_io_data <= 8'h00;
        end else if (!bus.cpu_wr) begin
            r_sel_ram <= !w_is_io;
            if (w_is_io)
                r_io_data <= w_io_rd_data;
        end
    end

    assign bus.cpu_din = r_sel_ram ? r_ram_rd : r_io_data;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_cycle_cnt <= 32'd0;
            r_cnt_latch <= 32'd0;
            r_done      <= 1'b0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
            if (w_io_rd && (w_off == 3'd4))
                r_cnt_latch <= r_cycle_cnt;
            if (w_io_wr && w_off[2])
                r_done <= 1'b1;
        end
    end

    assign program_done = r_done;

    assign w_fifo_full  = (r_count == CW'(TX_DEPTH));
    assign w_push       = w_io_wr && !w_fifo_full &&
                          (((w_off == 3'd0) && (bus.cpu_dout != 8'h00)) || w_off[2]);
    assign w_push_data  = w_off[2] ? 8'h00 : bus.cpu_dout;
    assign w_pop        = (r_count != '0) && tx_ready;
    assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);

    always_ff @(posedge clk_in) begin
        if (w_push)
            r_fifo[r_tail] <= w_push_data;
    end

    // Near-full leaves room for the write already in flight while the CPU sees the flag a cycle late.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_io_full <= 1'b0;
        end else begin
            if (w_push)
                r_tail <= r_tail + 1'b1;
            if (w_pop)
                r_head <= r_head + 1'b1;
            r_count   <= w_count_next;
            r_io_full <= (w_count_next >= CW'(TX_DEPTH - 2));
        end
    end

    assign tx_valid           = (r_count != '0);
    assign tx_data            = r_fifo[r_head];
    assign bus.io_buffer_full = r_io_full;
endmodule

// File: tb/tb_mem_io_responder.sv
// Scoreboard bench for mem_io_responder: read expectations are queued when issued and checked one cycle later.
module tb_mem_io_responder;
    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_pop;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready = 1'b0;
    logic       program_done;

    always #5 clk_in = ~clk_in;

    mem_io_responder_if bus_if();

    mem_io_responder dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .bus          (bus_if),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_pop       (rx_pop),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .tx_ready     (tx_ready),
        .program_done (program_done)
    );

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  q_exp [$];
    logic [7:0]  m_tx [$];
    logic [7:0]  m_ram [int];
    logic [31:0] m_cnt;
    logic [31:0] m_latch = 32'd0;
    logic [7:0]  m_last_din = 8'h00;
    logic        m_done = 1'b0;

    always @(posedge clk_in) begin
        if (rst_in) m_cnt <= 32'd0;
        else        m_cnt <= m_cnt + 32'd1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        bus_if.cpu_wr   = 1'b1;
        bus_if.cpu_a    = 32'h0003_0001;
        bus_if.cpu_dout = 8'h00;
        rx_valid        = 1'b0;
    endtask

    task automatic op(input logic wr, input logic [31:0] a, input logic [7:0] d,
                      input logic rxv = 1'b0, input logic [7:0] rxd = 8'h00);
        logic       is_io;
        logic [7:0] e;
        is_io           = (a[17:16] == 2'b11);
        bus_if.cpu_wr   = wr;
        bus_if.cpu_a    = a;
        bus_if.cpu_dout = d;
        rx_valid        = rxv;
        rx_data         = rxd;
        #1;
        if (!wr) begin
            if (!is_io) q_exp.push_back(m_ram[int'(a[16:0])]);
            else begin
                case (a[2:0])
                    3'd0: q_exp.push_back(rxv ? rxd : 8'h00);
                    3'd4: begin q_exp.push_back(m_cnt[7:0]); m_latch = m_cnt; end
                    3'd5: q_exp.push_back(m_latch[15:8]);
                    3'd6: q_exp.push_back(m_latch[23:16]);
                    3'd7: q_exp.push_back(m_latch[31:24]);
                    default: q_exp.push_back(8'h00);
                endcase
            end
        end
        chk("rx_pop", {31'd0, rx_pop}, {31'd0, (!wr && is_io && a[2:0] == 3'd0 && rxv)});
        $display("txn wr=%0d a=%05h dout=%02h rxv=%0d", wr, a[17:0], d, rxv);
        step();
        if (!wr) begin
            e = q_exp.pop_front();
            chk("cpu_din", {24'd0, bus_if.cpu_din}, {24'd0, e});
            m_last_din = e;
        end else begin
            chk("din_hold", {24'd0, bus_if.cpu_din}, {24'd0, m_last_din});
            if (!is_io) m_ram[int'(a[16:0])] = d;
            else if (a[2:0] == 3'd0 && d != 8'h00 && m_tx.size() < 16) m_tx.push_back(d);
            else if (a[2]) begin
                m_done = 1'b1;
                if (m_tx.size() < 16) m_tx.push_back(8'h00);
            end
        end
        chk("io_full", {31'd0, bus_if.io_buffer_full}, {31'd0, (m_tx.size() >= 14)});
        chk("done", {31'd0, program_done}, {31'd0, m_done});
        idle();
    endtask

    task automatic drain(input string tag);
        tx_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            chk({tag, "_valid"}, {31'd0, tx_valid}, {31'd0, (m_tx.size() != 0)});
            if (m_tx.size() == 0) break;
            chk({tag, "_data"}, {24'd0, tx_data}, {24'd0, m_tx.pop_front()});
            step();
            chk({tag, "_full"}, {31'd0, bus_if.io_buffer_full}, {31'd0, (m_tx.size() >= 14)});
        end
        tx_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst_in = 1'b1;
        step();
        step();
        rst_in = 1'b0;
        m_tx.delete();
        q_exp.delete();
        m_done     = 1'b0;
        m_latch    = 32'd0;
        m_last_din = 8'h00;
    endtask

    initial begin
        logic [31:0] addrs [8];
        logic [7:0]  vals  [8];

        do_reset();
        chk("rst_din",   {24'd0, bus_if.cpu_din}, 32'd0);
        chk("rst_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_done",  {31'd0, program_done}, 32'd0);
        chk("rst_full",  {31'd0, bus_if.io_buffer_full}, 32'd0);
        op(1'b0, 32'h0003_0005, 8'h00);

        op(1'b1, 32'h0000_0010, 8'hA5);
        op(1'b0, 32'h0000_0010, 8'h00);

        op(1'b0, 32'h0003_0000, 8'h00, 1'b1, 8'h41);
        op(1'b0, 32'h0003_0000, 8'h00, 1'b0, 8'h55);

        op(1'b1, 32'h0003_0002, 8'h55);
        op(1'b0, 32'h0003_0003, 8'h00);

        op(1'b1, 32'h0003_0000, 8'h48);
        op(1'b1, 32'h0003_0000, 8'h00);
        op(1'b1, 32'h0003_0000, 8'h69);
        drain("uart");

        for (int i = 0; i < 8; i++) begin
            addrs[i] = $urandom & 32'h0001_FFFF;
            vals[i]  = 8'($urandom);
            op(1'b1, addrs[i], vals[i]);
        end
        for (int i = 0; i < 8; i++) op(1'b0, addrs[i], 8'h00);
        for (int i = 0; i < 4; i++) begin
            op(1'b1, 32'h0000_1000 + 32'(i), 8'hC0 + 8'(i));
            op(1'b0, 32'h0000_1000 + 32'(i), 8'h00);
        end

        for (int i = 0; i < 17; i++) op(1'b1, 32'h0003_0000, 8'(i + 1));
        drain("fill");

        do_reset();
        for (int i = 0; i < 400 && m_cnt != 32'h0000_00FF; i++) step();
        op(1'b0, 32'h0003_0004, 8'h00);
        op(1'b0, 32'h0003_0005, 8'h00);
        op(1'b0, 32'h0003_0006, 8'h00);
        op(1'b0, 32'h0003_0007, 8'h00);

        op(1'b1, 32'h0003_0004, 8'h12);
        drain("stop");
        op(1'b1, 32'h0003_0000, 8'h33);
        op(1'b1, 32'h0003_0006, 8'h01);
        chk("pre_rst_valid", {31'd0, tx_valid}, 32'd1);
        rst_in = 1'b1;
        step();
        chk("mid_rst_valid", {31'd0, tx_valid}, 32'd0);
        chk("mid_rst_done",  {31'd0, program_done}, 32'd0);
        chk("mid_rst_full",  {31'd0, bus_if.io_buffer_full}, 32'd0);
        rst_in = 1'b0;
        m_tx.delete();
        m_done     = 1'b0;
        m_latch    = 32'd0;
        m_last_din = 8'h00;

        op(1'b1, 32'h0003_0000, 8'h7E);
        drain("post");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
